decode: RTL and testbench

- Decode stage directly downstream of the instruction fetch stage.
- Consumes the 16-bit instruction word from fetch each cycle, resolves loop brackets using a hardware return-address stack, and drives `branch_en`/`branch_val`/`stall` back into fetch combinationally.
- Issues a registered micro-op to the execute stage.
- Forward skips of zero-cell loops are handled internally by a skip state machine, with no fetch redirect.

---
 rtl/decode.sv | 189 ++++++++++++++++++
 tb/tb_decode.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode: bracket-resolving decode stage with a loop return-address stack and a zero-cell skip FSM.
// Optional macro DECODE_STACK_CHECK_EN adds sticky stack overflow/underflow detection on err.
//
// state  | meaning
// S_RUN  | normal decode: issue uops, push/branch/pop on loop brackets
// S_SKIP | forward-skipping a zero-cell loop body; all instructions dropped
module decode #(
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_en,
  input  logic [15:0] ins,
  input  logic [15:0] ins_pc,
  input  logic        cell_zero,
  output logic        branch_en,
  output logic [15:0] branch_val,
  output logic        stall,
  output logic        uop_valid,
  output logic [2:0]  uop_op,
  output logic [15:0] uop_imm,
  output logic        err
);

  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_MOVE   = 4'd2;
  localparam logic [3:0] OP_LOPEN  = 4'd3;
  localparam logic [3:0] OP_LCLOSE = 4'd4;
  localparam logic [3:0] OP_OUT    = 4'd5;
  localparam logic [3:0] OP_IN     = 4'd6;
  localparam int         SD_W      = SP_W + 4;

`ifdef DECODE_STACK_CHECK_EN
  // One extra bit so a completely full stack (sp == STACK_DEPTH) is representable.
  localparam int SPC_W = SP_W + 1;
`else
  localparam int SPC_W = SP_W;
`endif

  typedef enum logic {S_RUN, S_SKIP} state_t;

  state_t            r_state, w_state_nxt;
  logic [SPC_W-1:0]  r_sp, w_sp_nxt;
  logic [SD_W-1:0]   r_skip_depth, w_skip_depth_nxt;
  logic              r_uop_valid, w_uop_valid_nxt;
  logic [2:0]        r_uop_op, w_uop_op_nxt;
  logic [15:0]       r_uop_imm, w_uop_imm_nxt;
  logic [15:0]       r_stack [STACK_DEPTH];

  logic [3:0]        w_op;
  logic              w_is_bracket;
  logic              w_hazard;
  logic              w_push;
  logic              w_branch_en;
  logic              w_stall;
  logic              w_sp_full;
  logic              w_sp_empty;
  logic [SP_W-1:0]   w_top_idx;

  assign w_op         = ins[15:12];
  assign w_is_bracket = (w_op == OP_LOPEN) || (w_op == OP_LCLOSE);
  // A bracket right behind an ADD/IN must wait for execute to refresh cell_zero.
  assign w_hazard     = core_en && (r_state == S_RUN) && w_is_bracket && r_uop_valid &&
                        ((r_uop_op == OP_ADD[2:0]) || (r_uop_op == OP_IN[2:0]));
  assign w_top_idx    = r_sp[SP_W-1:0] - 1'b1;

`ifdef DECODE_STACK_CHECK_EN
  logic r_err;
  logic w_err_set;

  assign w_sp_full  = (r_sp == SPC_W'(STACK_DEPTH));
  assign w_sp_empty = (r_sp == '0);
  assign err        = r_err;
`else
  assign w_sp_full  = 1'b0;
  assign w_sp_empty = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_sp_nxt         = r_sp;
    w_skip_depth_nxt = r_skip_depth;
    w_uop_valid_nxt  = 1'b0;
    w_uop_op_nxt     = 3'd0;
    w_uop_imm_nxt    = 16'd0;
    w_push           = 1'b0;
    w_branch_en      = 1'b0;
    w_stall          = 1'b0;
`ifdef DECODE_STACK_CHECK_EN
    w_err_set        = 1'b0;
`endif
    if (!core_en) begin
      w_state_nxt      = S_RUN;
      w_sp_nxt         = '0;
      w_skip_depth_nxt = '0;
    end else if (r_state == S_SKIP) begin
      if (w_op == OP_LOPEN) begin
        if (r_skip_depth != '1) begin
          w_skip_depth_nxt = r_skip_depth + 1'b1;
        end
      end else if (w_op == OP_LCLOSE) begin
        w_skip_depth_nxt = r_skip_depth - 1'b1;
        if (r_skip_depth == SD_W'(1)) begin
          w_state_nxt = S_RUN;
        end
      end
    end else if (w_hazard) begin
      w_stall = 1'b1;
    end else begin
      case (w_op)
        OP_ADD, OP_MOVE, OP_OUT, OP_IN: begin
          w_uop_valid_nxt = 1'b1;
          w_uop_op_nxt    = w_op[2:0];
          w_uop_imm_nxt   = {{4{ins[11]}}, ins[11:0]};
        end
        OP_LOPEN: begin
          if (cell_zero) begin
            w_state_nxt      = S_SKIP;
            w_skip_depth_nxt = SD_W'(1);
          end else if (w_sp_full) begin
`ifdef DECODE_STACK_CHECK_EN
            w_err_set = 1'b1;
`endif
          end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + 1'b1;
          end
        end
        OP_LCLOSE: begin
          if (w_sp_empty) begin
`ifdef DECODE_STACK_CHECK_EN
            w_err_set = 1'b1;
`endif
          end else if (!cell_zero) begin
            w_branch_en = 1'b1;
          end else begin
            w_sp_nxt = r_sp - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign branch_en  = w_branch_en;
  assign branch_val = w_branch_en ? (r_stack[w_top_idx] + 16'd1) : 16'd0;
  assign stall      = w_stall;
  assign uop_valid  = r_uop_valid;
  assign uop_op     = r_uop_op;
  assign uop_imm    = r_uop_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_sp         <= '0;
      r_skip_depth <= '0;
      r_uop_valid  <= 1'b0;
      r_uop_op     <= 3'd0;
      r_uop_imm    <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_sp         <= w_sp_nxt;
      r_skip_depth <= w_skip_depth_nxt;
      r_uop_valid  <= w_uop_valid_nxt;
      r_uop_op     <= w_uop_op_nxt;
      r_uop_imm    <= w_uop_imm_nxt;
    end
  end

  // Stack contents are not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp[SP_W-1:0]] <= ins_pc;
    end
  end

`ifdef DECODE_STACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode.sv
// Testbench for decode: directed vector table, multi-cycle corner sequences, and random
// stimulus checked against a behavioural model of the bracket/stack/skip rules.
module tb_decode;
  localparam int STACK_DEPTH = 16;
  localparam int SP_W        = 4;
  localparam int SD_MAX      = (1 << (SP_W + 4)) - 1;
`ifdef DECODE_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_en;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        cell_zero;
  logic        branch_en;
  logic [15:0] branch_val;
  logic        stall;
  logic        uop_valid;
  logic [2:0]  uop_op;
  logic [15:0] uop_imm;
  logic        err;

  decode #(.STACK_DEPTH(STACK_DEPTH), .SP_W(SP_W)) dut (
    .clk(clk), .rst_n(rst_n), .core_en(core_en), .ins(ins), .ins_pc(ins_pc),
    .cell_zero(cell_zero), .branch_en(branch_en), .branch_val(branch_val), .stall(stall),
    .uop_valid(uop_valid), .uop_op(uop_op), .uop_imm(uop_imm), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: loop nesting count, remembered loop-start addresses, skip nesting.
  bit          m_skip;
  int          m_depth;
  int          m_sp;
  logic [15:0] m_mem [STACK_DEPTH];
  bit          m_uv;
  int          m_op;
  logic [15:0] m_imm;
  bit          m_err;

  task automatic model_reset();
    m_skip = 0; m_depth = 0; m_sp = 0; m_uv = 0; m_op = 0; m_imm = 0; m_err = 0;
  endtask

  task automatic run_cycle(input logic [15:0] i, input logic [15:0] pc, input bit cz,
                           input bit en, output bit o_st);
    int op;
    int v;
    bit e_br, e_st, n_uv;
    logic [15:0] e_bv, n_imm;
    int n_op;
    ins = i; ins_pc = pc; cell_zero = cz; core_en = en;
    op = int'(i[15:12]);
    e_br = 0; e_st = 0; e_bv = 0; n_uv = 0; n_op = 0; n_imm = 0;
    if (!en) begin
      m_skip = 0; m_depth = 0; m_sp = 0;
    end else if (m_skip) begin
      if (op == 3) m_depth = (m_depth < SD_MAX) ? m_depth + 1 : SD_MAX;
      else if (op == 4) begin
        m_depth--;
        if (m_depth == 0) m_skip = 0;
      end
    end else if ((op == 3 || op == 4) && m_uv && (m_op == 1 || m_op == 6)) begin
      e_st = 1;
    end else if (op == 1 || op == 2 || op == 5 || op == 6) begin
      n_uv = 1; n_op = op;
      v = int'(i[11:0]);
      if (v >= 2048) v = v - 4096;
      n_imm = v[15:0];
    end else if (op == 3) begin
      if (cz) begin
        m_skip = 1; m_depth = 1;
      end else if (CHK && m_sp == STACK_DEPTH) begin
        m_err = 1;
      end else begin
        m_mem[m_sp % STACK_DEPTH] = pc;
        m_sp = CHK ? m_sp + 1 : (m_sp + 1) % STACK_DEPTH;
      end
    end else if (op == 4) begin
      if (CHK && m_sp == 0) begin
        m_err = 1;
      end else if (!cz) begin
        e_br = 1;
        e_bv = m_mem[(m_sp + STACK_DEPTH - 1) % STACK_DEPTH] + 16'd1;
      end else begin
        m_sp = CHK ? m_sp - 1 : (m_sp + STACK_DEPTH - 1) % STACK_DEPTH;
      end
    end
    #2;
    chk("stall", stall, e_st);
    chk("branch_en", branch_en, e_br);
    if (e_br) chk("branch_val", branch_val, e_bv);
    @(posedge clk); #1;
    m_uv = n_uv; m_op = n_op; m_imm = n_imm;
    chk("uop_valid", uop_valid, n_uv);
    if (n_uv) begin
      chk("uop_op", uop_op, n_op);
      chk("uop_imm", uop_imm, n_imm);
    end
    chk("err", err, m_err);
    o_st = e_st;
  endtask

  task automatic rst_pulse();
    bit st;
    run_cycle(16'h1007, 16'h0300, 1'b0, 1'b1, st);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_uop_valid", uop_valid, 0);
    chk("async_rst_uop_op", uop_op, 0);
    chk("async_rst_uop_imm", uop_imm, 0);
    chk("async_rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] i;
    logic [15:0] pc;
    bit          cz;
    bit          st;
    bit          br;
    logic [15:0] bv;
    bit          uv;
    logic [2:0]  op;
    logic [15:0] imm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit st;
    logic [15:0] pc;
    int r, op;

    tbl.push_back('{16'h1003, 16'h0000, 0, 0, 0, 16'h0000, 1, 3'd1, 16'h0003});
    tbl.push_back('{16'h2FFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 3'd2, 16'hFFFF});
    tbl.push_back('{16'h3000, 16'h0010, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h0011, 0, 0, 1, 16'h0011, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h0012, 1, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h1001, 16'h0013, 0, 0, 0, 16'h0000, 1, 3'd1, 16'h0001});
    tbl.push_back('{16'h3000, 16'h0014, 0, 1, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h3000, 16'h0014, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h0015, 0, 0, 1, 16'h0015, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h0016, 1, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h3000, 16'h0017, 1, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h3000, 16'h0018, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h1001, 16'h0019, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h001A, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h1001, 16'h001B, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h4000, 16'h001C, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h1005, 16'h001D, 0, 0, 0, 16'h0000, 1, 3'd1, 16'h0005});
    tbl.push_back('{16'h6123, 16'h001E, 0, 0, 0, 16'h0000, 1, 3'd6, 16'h0123});
    tbl.push_back('{16'h4000, 16'h001F, 0, 1, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h7ABC, 16'h0020, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h5FFE, 16'h0021, 0, 0, 0, 16'h0000, 1, 3'd5, 16'hFFFE});
    tbl.push_back('{16'h0800, 16'h0022, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'hF123, 16'h0023, 0, 0, 0, 16'h0000, 0, 3'd0, 16'h0000});
    tbl.push_back('{16'h2800, 16'h0024, 0, 0, 0, 16'h0000, 1, 3'd2, 16'hF800});

    core_en = 1'b0; ins = 16'h0; ins_pc = 16'h0; cell_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_uop_op", uop_op, 0);
    chk("rst_uop_imm", uop_imm, 0);
    chk("rst_err", err, 0);
    chk("rst_branch_en", branch_en, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    core_en = 1'b1;

    foreach (tbl[k]) begin
      ins = tbl[k].i; ins_pc = tbl[k].pc; cell_zero = tbl[k].cz;
      #2;
      chk($sformatf("tbl%0d_stall", k), stall, tbl[k].st);
      chk($sformatf("tbl%0d_branch_en", k), branch_en, tbl[k].br);
      if (tbl[k].br) chk($sformatf("tbl%0d_branch_val", k), branch_val, tbl[k].bv);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_uop_valid", k), uop_valid, tbl[k].uv);
      if (tbl[k].uv) begin
        chk($sformatf("tbl%0d_uop_op", k), uop_op, tbl[k].op);
        chk($sformatf("tbl%0d_uop_imm", k), uop_imm, tbl[k].imm);
      end
      chk($sformatf("tbl%0d_err", k), err, 0);
    end

    rst_pulse();

    // Flush in the middle of a skip: back to RUN with an empty stack.
    run_cycle(16'h3000, 16'h0040, 1'b0, 1'b1, st);
    run_cycle(16'h3000, 16'h0041, 1'b1, 1'b1, st);
    run_cycle(16'h1001, 16'h0042, 1'b0, 1'b1, st);
    run_cycle(16'h1001, 16'h0043, 1'b0, 1'b0, st);
    run_cycle(16'h1002, 16'h0044, 1'b0, 1'b1, st);
    chk("flush_run_add_issued", uop_valid, 1);
    run_cycle(16'h2001, 16'h0045, 1'b0, 1'b1, st);
    run_cycle(16'h3000, 16'h0050, 1'b0, 1'b1, st);
    run_cycle(16'h4000, 16'h0051, 1'b0, 1'b1, st);
    run_cycle(16'h4000, 16'h0052, 1'b1, 1'b1, st);

    // 17 nested opens: overflows a 16-entry stack.
    for (int k = 0; k < 17; k++) run_cycle(16'h3000, 16'h0100 + 16'(k), 1'b0, 1'b1, st);
`ifdef DECODE_STACK_CHECK_EN
    chk("overflow_err", err, 1);
`endif
    run_cycle(16'h4000, 16'h0120, 1'b0, 1'b1, st);
    for (int k = 0; k < 17; k++) run_cycle(16'h4000, 16'h0121, 1'b1, 1'b1, st);
    run_cycle(16'h0000, 16'h0122, 1'b0, 1'b0, st);

    rst_pulse();
    run_cycle(16'h4000, 16'h0200, 1'b0, 1'b1, st);
`ifdef DECODE_STACK_CHECK_EN
    chk("underflow_err", err, 1);
    chk("underflow_no_branch", branch_en, 0);
`endif
    run_cycle(16'h0000, 16'h0201, 1'b0, 1'b0, st);

    // Skip-depth saturation: 300 opens inside a skip need only 255 closes to leave it.
    run_cycle(16'h3000, 16'h0400, 1'b1, 1'b1, st);
    for (int k = 0; k < 300; k++) run_cycle(16'h3000, 16'h0401, 1'b0, 1'b1, st);
    for (int k = 0; k < 254; k++) run_cycle(16'h4000, 16'h0402, 1'b0, 1'b1, st);
    run_cycle(16'h1001, 16'h0403, 1'b0, 1'b1, st);
    chk("sat_still_skipping", uop_valid, 0);
    run_cycle(16'h4000, 16'h0404, 1'b0, 1'b1, st);
    run_cycle(16'h1001, 16'h0405, 1'b0, 1'b1, st);
    chk("sat_exit_add", uop_valid, 1);

    pc = 16'h1000;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = (r == 0) ? 1 : ((r == 1) ? 2 : (($urandom_range(0, 1) != 0) ? 5 : 6));
      else if (r == 3) op = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(7, 15);
      else if (r < 6)  op = 3;
      else if (r < 8)  op = 4;
      else             op = 1;
      run_cycle({4'(op), 12'($urandom)}, pc, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 49) != 0), st);
      if (!st) pc = pc + 16'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
